// File: rtl/mms_pkg.sv
// Shared Sv32 walker types: PTE/satp layouts, walker states, fault codes.
package mms_pkg;

    localparam int SV32_LEVELS   = 2;
    localparam int PTE_BYTES     = 4;
    localparam int PAGE_OFFSET_W = 12;
    localparam int PPN_W         = 22;

    // Sv32 PTE, MSB first so a 32-bit word casts straight onto it
    typedef struct packed {
        logic [PPN_W-1:0] ppn;
        logic [1:0]       rsw;
        logic             d;
        logic             a;
        logic             g;
        logic             u;
        logic             x;
        logic             w;
        logic             r;
        logic             v;
    } pte_t;

    typedef struct packed {
        logic             mode;
        logic [8:0]       asid;
        logic [PPN_W-1:0] ppn;
    } satp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_REQ,
        S_L1_WAIT,
        S_L0_REQ,
        S_L0_WAIT,
        S_DONE,
        S_DRAIN
    } ptw_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE   = 2'd0,
        FAULT_PAGE   = 2'd1,
        FAULT_ACCESS = 2'd2
    } ptw_fault_e;

endpackage

// File: rtl/itlb_ptw_pte_check.sv
// Combinational Sv32 PTE classifier for one walk level (level=1 is the root).
// Optional: ITLB_PTW_AD_CHECK_EN makes a leaf with A=0 a page fault.
module itlb_ptw_pte_check
    import mms_pkg::*;
(
    input  pte_t pte,
    input  logic level,
    output logic page_fault,
    output logic descend
);

    logic invalid;
    logic leaf;
    logic misaligned;
    logic no_exec;
    logic a_fault;
    logic unused_ok;

    // Classify the PTE and fold the classes into walk decisions
    always_comb begin
        invalid    = !pte.v || (!pte.r && pte.w) || (pte.rsw != 2'b00);
        leaf       = pte.r || pte.w || pte.x;
        // a megapage must be 4 MiB aligned: its low PPN slice has to be zero
        misaligned = level && (pte.ppn[9:0] != 10'd0);
        no_exec    = !pte.x;
`ifdef ITLB_PTW_AD_CHECK_EN
        a_fault    = !pte.a;
`else
        a_fault    = 1'b0;
`endif
        descend    = !invalid && !leaf && level;
        page_fault = invalid || (!leaf && !level) ||
                     (leaf && (misaligned || no_exec || a_fault));
    end

    // fields the classifier deliberately ignores
    assign unused_ok = ^{pte.u, pte.g, pte.d, pte.a, pte.ppn[PPN_W-1:10]};

endmodule

// File: rtl/itlb_ptw.sv
// Sv32 page-table walker for ITLB misses: one walk at a time, two levels,
// emits a one-cycle refill/fault pulse. Optional: ITLB_PTW_AD_CHECK_EN.
module itlb_ptw
    import mms_pkg::*;
#(
    parameter int PA_W  = 34,
    parameter int VPN_W = 20,
    parameter int PTE_W = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [31:0]      satp_i,
    input  logic             flush_i,
    input  logic             miss_valid_i,
    output logic             miss_ready_o,
    input  logic [VPN_W-1:0] miss_vpn_i,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic [PA_W-1:0]  mem_req_addr_o,
    input  logic             mem_rsp_valid_i,
    input  logic [PTE_W-1:0] mem_rsp_data_i,
    input  logic             mem_rsp_err_i,
    output logic             refill_valid_o,
    output logic [VPN_W-1:0] refill_vpn_o,
    output logic [PTE_W-1:0] refill_pte_o,
    output logic             refill_super_o,
    output logic [1:0]       fault_cause_o
);

    ptw_state_e        state_q, state_d;
    satp_t             satp;
    pte_t              rsp_pte;
    logic [VPN_W-1:0]  vpn_q;
    logic [PPN_W-1:0]  base_q;
    logic [9:0]        idx;
    logic              level, page_fault, descend;
    logic              load_res, load_base;
    ptw_fault_e        res_cause_d, res_cause_q;
    logic [PTE_W-1:0]  res_pte_d, res_pte_q;
    logic              res_super_d, res_super_q;
    logic [VPN_W-1:0]  res_vpn_q;
    logic              unused_ok;

    assign satp      = satp_t'(satp_i);
    assign rsp_pte   = pte_t'(mem_rsp_data_i);
    assign unused_ok = ^satp.asid;
    assign level     = (state_q == S_L1_WAIT);

    itlb_ptw_pte_check u_chk (
        .pte        (rsp_pte),
        .level      (level),
        .page_fault (page_fault),
        .descend    (descend)
    );

    // PTE address: table base page plus VPN slice scaled by PTE size
    assign idx = (state_q == S_L1_REQ) ? vpn_q[VPN_W-1:VPN_W/2] : vpn_q[VPN_W/2-1:0];
    assign mem_req_addr_o = (PA_W'(base_q) << PAGE_OFFSET_W) +
                            (PA_W'(idx) << $clog2(PTE_BYTES));

    // a flush withdraws the request before it can be accepted
    assign mem_req_valid_o = ((state_q == S_L1_REQ) || (state_q == S_L0_REQ)) && !flush_i;
    assign miss_ready_o    = (state_q == S_IDLE);
    assign refill_valid_o  = (state_q == S_DONE) && !flush_i;
    assign refill_vpn_o    = res_vpn_q;
    assign refill_pte_o    = res_pte_q;
    assign refill_super_o  = res_super_q;
    assign fault_cause_o   = res_cause_q;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state and result selection
    always_comb begin
        state_d     = state_q;
        load_res    = 1'b0;
        load_base   = 1'b0;
        res_cause_d = FAULT_NONE;
        res_pte_d   = '0;
        res_super_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss_valid_i) begin
                    if (!satp.mode) begin
                        // bare mode should never miss in the ITLB
                        state_d     = S_DONE;
                        load_res    = 1'b1;
                        res_cause_d = FAULT_PAGE;
                    end else begin
                        state_d = S_L1_REQ;
                    end
                end
            end
            S_L1_REQ, S_L0_REQ: begin
                if (flush_i)              state_d = S_IDLE;
                else if (mem_req_ready_i) state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
            end
            S_L1_WAIT, S_L0_WAIT: begin
                if (flush_i) begin
                    // a response arriving with the flush is simply dropped
                    state_d = mem_rsp_valid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rsp_valid_i) begin
                    if (mem_rsp_err_i) begin
                        state_d     = S_DONE;
                        load_res    = 1'b1;
                        res_cause_d = FAULT_ACCESS;
                    end else if (page_fault) begin
                        state_d     = S_DONE;
                        load_res    = 1'b1;
                        res_cause_d = FAULT_PAGE;
                    end else if (descend) begin
                        state_d   = S_L0_REQ;
                        load_base = 1'b1;
                    end else begin
                        state_d     = S_DONE;
                        load_res    = 1'b1;
                        res_pte_d   = mem_rsp_data_i;
                        res_super_d = level;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_DRAIN: if (mem_rsp_valid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Walk context and registered result
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vpn_q       <= '0;
            base_q      <= '0;
            res_vpn_q   <= '0;
            res_pte_q   <= '0;
            res_super_q <= 1'b0;
            res_cause_q <= FAULT_NONE;
        end else begin
            if (miss_valid_i && miss_ready_o) begin
                vpn_q  <= miss_vpn_i;
                base_q <= satp.ppn;
            end
            if (load_base) base_q <= rsp_pte.ppn;
            if (load_res) begin
                res_vpn_q   <= (state_q == S_IDLE) ? miss_vpn_i : vpn_q;
                res_pte_q   <= res_pte_d;
                res_super_q <= res_super_d;
                res_cause_q <= res_cause_d;
            end
        end
    end

endmodule

// File: tb/tb_itlb_ptw.sv
// Randomized bench for itlb_ptw: sparse page-table memory, Sv32 walk model.
module tb_itlb_ptw;

    localparam int PA_W  = 34;
    localparam int VPN_W = 20;
    localparam int PTE_W = 32;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic [31:0]      satp_i;
    logic             flush_i;
    logic             miss_valid_i;
    logic             miss_ready_o;
    logic [VPN_W-1:0] miss_vpn_i;
    logic             mem_req_valid_o;
    logic             mem_req_ready_i;
    logic [PA_W-1:0]  mem_req_addr_o;
    logic             mem_rsp_valid_i;
    logic [PTE_W-1:0] mem_rsp_data_i;
    logic             mem_rsp_err_i;
    logic             refill_valid_o;
    logic [VPN_W-1:0] refill_vpn_o;
    logic [PTE_W-1:0] refill_pte_o;
    logic             refill_super_o;
    logic [1:0]       fault_cause_o;

    itlb_ptw #(.PA_W(PA_W), .VPN_W(VPN_W), .PTE_W(PTE_W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .satp_i(satp_i), .flush_i(flush_i),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_vpn_i(miss_vpn_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
        .refill_valid_o(refill_valid_o), .refill_vpn_o(refill_vpn_o),
        .refill_pte_o(refill_pte_o), .refill_super_o(refill_super_o),
        .fault_cause_o(fault_cause_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0]     pt      [logic [PA_W-1:0]];
    bit              err_map [logic [PA_W-1:0]];
    logic [PA_W-1:0] req_q[$];
    logic [PA_W-1:0] exp_req[$];
    int              fixed_lat = 0;
    bit              rdy_rand  = 1'b0;
    bit              stall     = 1'b0;
    bit              m_pend    = 1'b0;
    int              m_lat     = 0;
    logic [PA_W-1:0] m_addr;

    initial begin
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
        mem_rsp_data_i  = '0;
        forever begin
            @(negedge clk_i);
            mem_rsp_valid_i = 1'b0;
            mem_rsp_err_i   = 1'b0;
            mem_rsp_data_i  = '0;
            if (!rstn_i) m_pend = 1'b0;
            if (m_pend) begin
                if (m_lat == 0) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_err_i   = (err_map.exists(m_addr) != 0);
                    mem_rsp_data_i  = pt.exists(m_addr) ? pt[m_addr] : 32'h0;
                    m_pend = 1'b0;
                end else begin
                    m_lat--;
                end
            end
            mem_req_ready_i = !stall && (!rdy_rand || ($urandom_range(0, 3) != 0));
            #1;
            if (rstn_i && mem_req_valid_o && mem_req_ready_i) begin
                req_q.push_back(mem_req_addr_o);
                m_addr = mem_req_addr_o;
                m_pend = 1'b1;
                m_lat  = rdy_rand ? int'($urandom_range(0, 3)) : fixed_lat;
            end
        end
    end

    // ---------------- result monitor ----------------
    typedef struct {
        logic [VPN_W-1:0] vpn;
        logic [31:0]      pte;
        logic             sup;
        logic [1:0]       cause;
        int               cyc;
    } res_t;

    res_t res_q[$];
    res_t mon_r;
    int   cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk_i);
        #2;
        if (refill_valid_o) begin
            mon_r.vpn   = refill_vpn_o;
            mon_r.pte   = refill_pte_o;
            mon_r.sup   = refill_super_o;
            mon_r.cause = fault_cause_o;
            mon_r.cyc   = cyc;
            res_q.push_back(mon_r);
        end
    end

    // ---------------- Sv32 walk reference ----------------
    function automatic void model(input logic [31:0] satp, input logic [19:0] vpn,
                                  output logic [1:0] cause, output logic [31:0] pte,
                                  output logic sup);
        logic [PA_W-1:0] a, pa;
        logic [31:0]     p;
        logic [9:0]      vi;
        exp_req.delete();
        cause = 2'd0; pte = 32'h0; sup = 1'b0;
        if (!satp[31]) begin cause = 2'd1; return; end
        a = PA_W'(satp[21:0]) * 4096;
        for (int i = 1; i >= 0; i--) begin
            vi = (i == 1) ? vpn[19:10] : vpn[9:0];
            pa = a + PA_W'(vi) * 4;
            exp_req.push_back(pa);
            if (err_map.exists(pa)) begin cause = 2'd2; return; end
            p = pt.exists(pa) ? pt[pa] : 32'h0;
            if (!p[0] || (!p[1] && p[2]) || (p[9:8] != 2'b00)) begin cause = 2'd1; return; end
            if (p[3:1] == 3'b000) begin
                if (i == 0) begin cause = 2'd1; return; end
                a = PA_W'(p[31:10]) * 4096;
            end else begin
                if (i == 1 && p[19:10] != 10'd0) begin cause = 2'd1; return; end
                if (!p[3]) begin cause = 2'd1; return; end
`ifdef ITLB_PTW_AD_CHECK_EN
                if (!p[6]) begin cause = 2'd1; return; end
`endif
                pte = p;
                sup = (i == 1);
                return;
            end
        end
    endfunction

    // one walk, checked for result, pulse count, request list and optionally latency
    task automatic do_walk(input string tag, input logic [31:0] satp, input logic [19:0] vpn,
                           input int exp_lat, input int stall_n);
        logic [1:0]  ec;
        logic [31:0] ep;
        logic        es;
        int          t0, waited;
        model(satp, vpn, ec, ep, es);
        req_q.delete();
        res_q.delete();
        @(negedge clk_i);
        waited = 0;
        while (!miss_ready_o && waited < 50) begin @(negedge clk_i); waited++; end
        chk({tag, " ready"}, 64'(miss_ready_o), 64'd1);
        stall = (stall_n > 0);
        satp_i = satp; miss_vpn_i = vpn; miss_valid_i = 1'b1; t0 = cyc;
        @(negedge clk_i);
        miss_valid_i = 1'b0;
        miss_vpn_i   = VPN_W'($urandom);
        satp_i       = $urandom;
        for (int k = 0; k < stall_n; k++) begin
            #1;
            chk({tag, " stall valid"}, 64'(mem_req_valid_o), 64'd1);
            chk({tag, " stall addr"}, 64'(mem_req_addr_o), 64'(exp_req[0]));
            @(negedge clk_i);
        end
        stall = 1'b0;
        waited = 0;
        while (res_q.size() == 0 && waited < 300) begin @(negedge clk_i); waited++; end
        repeat (3) @(negedge clk_i);
        chk({tag, " pulses"}, 64'(res_q.size()), 64'd1);
        if (res_q.size() > 0) begin
            chk({tag, " vpn"},   64'(res_q[0].vpn),   64'(vpn));
            chk({tag, " pte"},   64'(res_q[0].pte),   64'(ep));
            chk({tag, " super"}, 64'(res_q[0].sup),   64'(es));
            chk({tag, " cause"}, 64'(res_q[0].cause), 64'(ec));
            if (exp_lat > 0) chk({tag, " latency"}, 64'(res_q[0].cyc - t0), 64'(exp_lat));
        end
        chk({tag, " nreq"}, 64'(req_q.size()), 64'(exp_req.size()));
        for (int k = 0; k < req_q.size() && k < exp_req.size(); k++)
            chk({tag, " addr"}, 64'(req_q[k]), 64'(exp_req[k]));
    endtask

    // abort a walk in L1_WAIT; response arrives lat cycles later (0 = same cycle)
    task automatic flush_walk(input string tag, input int lat);
        fixed_lat = lat;
        req_q.delete();
        res_q.delete();
        @(negedge clk_i);
        satp_i = 32'h8000_0080; miss_vpn_i = 20'h12345; miss_valid_i = 1'b1;
        @(negedge clk_i);
        miss_valid_i = 1'b0;
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        repeat (8) @(negedge clk_i);
        chk({tag, " no pulse"}, 64'(res_q.size()), 64'd0);
        chk({tag, " ready"},    64'(miss_ready_o), 64'd1);
        chk({tag, " nreq"},     64'(req_q.size()), 64'd1);
        chk({tag, " req idle"}, 64'(mem_req_valid_o), 64'd0);
    endtask

    task automatic set_t1();
        pt.delete();
        err_map.delete();
        pt[34'h0080120] = 32'h00024001;
        pt[34'h0090D14] = 32'h0002AC4B;
    endtask

    function automatic logic [31:0] rand_pte(input bit top);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0, 1: r = {r[31:10], 10'h001};
            2: begin
                if (top && $urandom_range(0, 1) == 1) r[19:10] = 10'd0;
                r[9:0] = 10'h0CB;
            end
            3: r = $urandom;
            4: r = 32'h0;
            default: begin r[0] = 1'b1; r[9:8] = 2'b00; end
        endcase
        return r;
    endfunction

    logic [31:0]     r_satp, r_pte;
    logic [19:0]     r_vpn;
    logic [PA_W-1:0] r_a1, r_a0;

    initial begin
        satp_i = 32'h0; flush_i = 1'b0; miss_valid_i = 1'b0; miss_vpn_i = '0;
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset outs", 64'({mem_req_valid_o, refill_valid_o, refill_vpn_o, refill_pte_o,
                               refill_super_o, fault_cause_o}), 64'd0);
        chk("reset ready", 64'(miss_ready_o), 64'd1);
        rstn_i = 1'b1;

        rdy_rand = 1'b0; fixed_lat = 0;
        set_t1();
        do_walk("t1 two-level", 32'h8000_0080, 20'h12345, 5, 0);
        if (res_q.size() > 0) chk("t1 pte const", 64'(res_q[0].pte), 64'h0002AC4B);

        pt[34'h0080120] = 32'h0002AC4B;
        do_walk("t2 misaligned", 32'h8000_0080, 20'h12345, 0, 0);

        pt[34'h0080120] = 32'h20000049;
        do_walk("t3 megapage", 32'h8000_0080, 20'h12345, 0, 0);
        if (res_q.size() > 0) chk("t3 super const", 64'(res_q[0].sup), 64'd1);

        set_t1();
        err_map[34'h0080120] = 1'b1;
        do_walk("t4 access", 32'h8000_0080, 20'h12345, 0, 0);

        set_t1();
        pt[34'h0090D14] = 32'h0;
        do_walk("t4 l0 zero", 32'h8000_0080, 20'h12345, 0, 0);

        do_walk("bare", 32'h0000_0080, 20'h0ABCD, 0, 0);

        set_t1();
        flush_walk("flush wait", 3);
        fixed_lat = 0;
        do_walk("after flush", 32'h8000_0080, 20'h12345, 5, 0);
        flush_walk("flush+rsp", 0);
        fixed_lat = 0;
        do_walk("after flush2", 32'h8000_0080, 20'h12345, 5, 0);

        do_walk("stall", 32'h8000_0080, 20'h12345, 0, 4);

        // reset in the middle of a walk, result registers hold a prior refill
        fixed_lat = 5;
        @(negedge clk_i);
        satp_i = 32'h8000_0080; miss_vpn_i = 20'h12345; miss_valid_i = 1'b1;
        @(negedge clk_i);
        miss_valid_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        chk("midreset outs", 64'({mem_req_valid_o, refill_valid_o, refill_vpn_o, refill_pte_o,
                                  refill_super_o, fault_cause_o}), 64'd0);
        chk("midreset ready", 64'(miss_ready_o), 64'd1);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        fixed_lat = 0;
        do_walk("after reset", 32'h8000_0080, 20'h12345, 5, 0);

        rdy_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            pt.delete();
            err_map.delete();
            r_satp = $urandom;
            r_satp[31] = ($urandom_range(0, 9) != 0);
            r_satp[21:0] = 22'($urandom_range(0, 255));
            r_vpn = 20'($urandom);
            r_a1 = PA_W'(r_satp[21:0]) * 4096 + PA_W'(r_vpn[19:10]) * 4;
            r_pte = rand_pte(1'b1);
            pt[r_a1] = r_pte;
            if ($urandom_range(0, 7) == 0) err_map[r_a1] = 1'b1;
            r_a0 = PA_W'(r_pte[31:10]) * 4096 + PA_W'(r_vpn[9:0]) * 4;
            if (r_a0 != r_a1) begin
                pt[r_a0] = rand_pte(1'b0);
                if ($urandom_range(0, 7) == 0) err_map[r_a0] = 1'b1;
            end
            do_walk("rand", r_satp, r_vpn, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
